// File: rtl/tcp_udp_rule_classer_pkg.sv
// Shared types and constants for the L4 rule classifier: rule word layout,
// match modes and the IP protocol numbers that drive the TCP/UDP/ICMP flags.
package tcp_udp_rule_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_DST    = 2'd1,
        MODE_SRC    = 2'd2,
        MODE_EITHER = 2'd3
    } mode_e;

    typedef struct packed {
        mode_e       mode;
        logic [7:0]  proto;
        logic [15:0] port;
    } rule_t;

    localparam logic [7:0] TCP_PROTO  = 8'd6;
    localparam logic [7:0] UDP_PROTO  = 8'd17;
    localparam logic [7:0] ICMP_PROTO = 8'd1;

    localparam int CFG_PORT_LSB  = 0;
    localparam int CFG_PROTO_LSB = 16;
    localparam int CFG_MODE_LSB  = 24;

    function automatic rule_t cfg_to_rule(input logic [31:0] data);
        rule_t r;
        r.port  = data[CFG_PORT_LSB +: 16];
        r.proto = data[CFG_PROTO_LSB +: 8];
        r.mode  = mode_e'(data[CFG_MODE_LSB +: 2]);
        return r;
    endfunction

endpackage

// File: rtl/tcp_udp_rule_classer_if.sv
// Header-parser, configuration and result signals of the rule classifier,
// with the classifier as slave and its driver/consumer as master.
interface tcp_udp_rule_classer_if #(
    parameter int RULES = 8,
    parameter int CNT_W = 32
);
    localparam int ADDR_W = $clog2(RULES);

    logic              clken_i;
    logic              sop_i;
    logic [7:0]        ip_prot_i;
    logic              ip_prot_en_i;
    logic [15:0]       port_src_i;
    logic              port_src_en_i;
    logic [15:0]       port_dst_i;
    logic              port_dst_en_i;
    logic              hdr_done_i;
    logic              cfg_wr_i;
    logic [ADDR_W-1:0] cfg_addr_i;
    logic [31:0]       cfg_data_i;
    logic              cnt_clr_i;
    logic [CNT_W-1:0]  cnt_rd_o;
    logic              res_valid_o;
    logic [RULES-1:0]  rule_hit_o;
    logic              hit_any_o;
    logic [ADDR_W-1:0] first_hit_o;
    logic              tcp_o;
    logic              udp_o;
    logic              icmp_o;

    modport slave (
        input  clken_i, sop_i, ip_prot_i, ip_prot_en_i, port_src_i, port_src_en_i,
               port_dst_i, port_dst_en_i, hdr_done_i, cfg_wr_i, cfg_addr_i,
               cfg_data_i, cnt_clr_i,
        output cnt_rd_o, res_valid_o, rule_hit_o, hit_any_o, first_hit_o,
               tcp_o, udp_o, icmp_o
    );

    modport master (
        output clken_i, sop_i, ip_prot_i, ip_prot_en_i, port_src_i, port_src_en_i,
               port_dst_i, port_dst_en_i, hdr_done_i, cfg_wr_i, cfg_addr_i,
               cfg_data_i, cnt_clr_i,
        input  cnt_rd_o, res_valid_o, rule_hit_o, hit_any_o, first_hit_o,
               tcp_o, udp_o, icmp_o
    );

endinterface

// File: rtl/tcp_udp_rule_classer_match.sv
// Combinational single-rule comparator: protocol must be seen and equal, and
// the port(s) selected by the rule mode must be seen and equal.
module tcp_udp_rule_match
    import tcp_udp_rule_pkg::*;
(
    input  rule_t       i_rule,
    input  logic [7:0]  i_prot,
    input  logic        i_prot_vld,
    input  logic [15:0] i_src,
    input  logic        i_src_vld,
    input  logic [15:0] i_dst,
    input  logic        i_dst_vld,
    output logic        o_hit
);
    logic w_prot_ok;
    logic w_src_ok;
    logic w_dst_ok;

    assign w_prot_ok = i_prot_vld && (i_prot == i_rule.proto);
    assign w_src_ok  = i_src_vld  && (i_src  == i_rule.port);
    assign w_dst_ok  = i_dst_vld  && (i_dst  == i_rule.port);

    always_comb begin
        o_hit = 1'b0;
        unique case (i_rule.mode)
            MODE_OFF:    o_hit = 1'b0;
            MODE_DST:    o_hit = w_prot_ok && w_dst_ok;
            MODE_SRC:    o_hit = w_prot_ok && w_src_ok;
            MODE_EITHER: o_hit = w_prot_ok && (w_src_ok || w_dst_ok);
        endcase
    end

endmodule

// File: rtl/tcp_udp_rule_classer.sv
// Programmable L4 rule classifier: field capture, rule table, per-rule match,
// priority encode and registered results. Hit counters under TCP_UDP_RULE_CNT_EN.
module tcp_udp_rule_classer
    import tcp_udp_rule_pkg::*;
#(
    parameter int RULES = 8,
    parameter int CNT_W = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    tcp_udp_rule_classer_if.slave   bus
);
    localparam int ADDR_W = $clog2(RULES);

    logic [7:0]        r_prot;
    logic              r_prot_vld;
    logic [15:0]       r_src;
    logic              r_src_vld;
    logic [15:0]       r_dst;
    logic              r_dst_vld;
    logic [7:0]        w_prot;
    logic              w_prot_vld;
    logic [15:0]       w_src;
    logic              w_src_vld;
    logic [15:0]       w_dst;
    logic              w_dst_vld;
    rule_t             r_rules [RULES];
    logic [RULES-1:0]  w_hit;
    logic [ADDR_W-1:0] w_first;
    logic              r_res_valid;
    logic [RULES-1:0]  r_rule_hit;
    logic [ADDR_W-1:0] r_first;
    logic              r_tcp;
    logic              r_udp;
    logic              r_icmp;

    // Next capture state doubles as the evaluation view, so a strobe
    // coincident with hdr_done_i (or sop_i) is seen by that evaluation.
    always_comb begin
        w_prot_vld = r_prot_vld & ~bus.sop_i;
        w_prot     = r_prot;
        w_src_vld  = r_src_vld & ~bus.sop_i;
        w_src      = r_src;
        w_dst_vld  = r_dst_vld & ~bus.sop_i;
        w_dst      = r_dst;
        if (bus.ip_prot_en_i) begin
            w_prot_vld = 1'b1;
            w_prot     = bus.ip_prot_i;
        end
        if (bus.port_src_en_i) begin
            w_src_vld = 1'b1;
            w_src     = bus.port_src_i;
        end
        if (bus.port_dst_en_i) begin
            w_dst_vld = 1'b1;
            w_dst     = bus.port_dst_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_prot     <= '0;
            r_prot_vld <= 1'b0;
            r_src      <= '0;
            r_src_vld  <= 1'b0;
            r_dst      <= '0;
            r_dst_vld  <= 1'b0;
        end else if (bus.clken_i) begin
            r_prot     <= w_prot;
            r_prot_vld <= w_prot_vld;
            r_src      <= w_src;
            r_src_vld  <= w_src_vld;
            r_dst      <= w_dst;
            r_dst_vld  <= w_dst_vld;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < RULES; i++) r_rules[i] <= rule_t'('0);
        end else if (bus.cfg_wr_i && (int'(bus.cfg_addr_i) < RULES)) begin
            r_rules[bus.cfg_addr_i] <= cfg_to_rule(bus.cfg_data_i);
        end
    end

    for (genvar g = 0; g < RULES; g++) begin : g_match
        tcp_udp_rule_match u_match (
            .i_rule     (r_rules[g]),
            .i_prot     (w_prot),
            .i_prot_vld (w_prot_vld),
            .i_src      (w_src),
            .i_src_vld  (w_src_vld),
            .i_dst      (w_dst),
            .i_dst_vld  (w_dst_vld),
            .o_hit      (w_hit[g])
        );
    end

    always_comb begin
        w_first = '0;
        for (int i = RULES - 1; i >= 0; i--) begin
            if (w_hit[i]) w_first = ADDR_W'(i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_res_valid <= 1'b0;
            r_rule_hit  <= '0;
            r_first     <= '0;
            r_tcp       <= 1'b0;
            r_udp       <= 1'b0;
            r_icmp      <= 1'b0;
        end else if (bus.clken_i) begin
            r_res_valid <= bus.hdr_done_i;
            if (bus.hdr_done_i) begin
                r_rule_hit <= w_hit;
                r_first    <= w_first;
                r_tcp      <= w_prot_vld && (w_prot == TCP_PROTO);
                r_udp      <= w_prot_vld && (w_prot == UDP_PROTO);
                r_icmp     <= w_prot_vld && (w_prot == ICMP_PROTO);
            end
        end
    end

    assign bus.res_valid_o = r_res_valid;
    assign bus.rule_hit_o  = r_rule_hit;
    assign bus.hit_any_o   = |r_rule_hit;
    assign bus.first_hit_o = r_first;
    assign bus.tcp_o       = r_tcp;
    assign bus.udp_o       = r_udp;
    assign bus.icmp_o      = r_icmp;

`ifdef TCP_UDP_RULE_CNT_EN
    logic [CNT_W-1:0] r_cnt [RULES];
    logic [CNT_W-1:0] r_cnt_rd;

    // Clear wins over a coincident increment; counters stick at all-ones.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < RULES; i++) r_cnt[i] <= '0;
        end else if (bus.cnt_clr_i) begin
            for (int i = 0; i < RULES; i++) r_cnt[i] <= '0;
        end else if (bus.clken_i && bus.hdr_done_i) begin
            for (int i = 0; i < RULES; i++) begin
                if (w_hit[i] && (r_cnt[i] != '1)) r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt_rd <= '0;
        end else if (int'(bus.cfg_addr_i) < RULES) begin
            r_cnt_rd <= r_cnt[bus.cfg_addr_i];
        end else begin
            r_cnt_rd <= '0;
        end
    end

    assign bus.cnt_rd_o = r_cnt_rd;
`else
    logic w_unused_cnt_clr;

    assign w_unused_cnt_clr = bus.cnt_clr_i;
    assign bus.cnt_rd_o     = '0;
`endif

endmodule

// File: tb/tb_tcp_udp_rule_classer.sv
// Self-checking bench for tcp_udp_rule_classer: a reference rule model pushes
// expected results to a queue as headers complete; tasks pop and compare.
module tb_tcp_udp_rule_classer;
    import tcp_udp_rule_pkg::*;

    localparam int RULES = 8;
    localparam int CNT_W = 8;
    localparam int RW    = RULES + 1 + 3 + 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    logic [RW-1:0] sb_q[$];
    logic [RW-1:0] exp_v;
    logic [1:0]    m_mode  [RULES];
    logic [7:0]    m_proto [RULES];
    logic [15:0]   m_port  [RULES];

    tcp_udp_rule_classer_if #(.RULES(RULES), .CNT_W(CNT_W)) bus ();

    tcp_udp_rule_classer #(.RULES(RULES), .CNT_W(CNT_W)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [RW-1:0] model(input logic pv, input logic [7:0] p,
                                            input logic sv, input logic [15:0] s,
                                            input logic dv, input logic [15:0] d);
        logic [RULES-1:0] h;
        logic [2:0]       f;
        logic             found;
        logic             pm;
        logic             portm;
        h = '0; f = '0; found = 1'b0;
        for (int i = 0; i < RULES; i++) begin
            pm = pv && (p == m_proto[i]);
            case (m_mode[i])
                2'd1:    portm = dv && (d == m_port[i]);
                2'd2:    portm = sv && (s == m_port[i]);
                2'd3:    portm = (dv && (d == m_port[i])) || (sv && (s == m_port[i]));
                default: portm = 1'b0;
            endcase
            h[i] = pm && portm;
            if (h[i] && !found) begin
                f = 3'(i);
                found = 1'b1;
            end
        end
        return {h, |h, f, pv && (p == 8'd6), pv && (p == 8'd17), pv && (p == 8'd1)};
    endfunction

    function automatic logic [RW:0] obs();
        return {bus.res_valid_o, bus.rule_hit_o, bus.hit_any_o, bus.first_hit_o,
                bus.tcp_o, bus.udp_o, bus.icmp_o};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.clken_i = 1'b1;       bus.sop_i = 1'b0;
        bus.ip_prot_i = '0;       bus.ip_prot_en_i = 1'b0;
        bus.port_src_i = '0;      bus.port_src_en_i = 1'b0;
        bus.port_dst_i = '0;      bus.port_dst_en_i = 1'b0;
        bus.hdr_done_i = 1'b0;    bus.cfg_wr_i = 1'b0;
        bus.cfg_addr_i = '0;      bus.cfg_data_i = '0;
        bus.cnt_clr_i = 1'b0;
    endtask

    task automatic cfg_write(input int idx, input logic [1:0] mode,
                             input logic [7:0] proto, input logic [15:0] port);
        m_mode[idx] = mode; m_proto[idx] = proto; m_port[idx] = port;
        bus.cfg_wr_i = 1'b1;
        bus.cfg_addr_i = 3'(idx);
        bus.cfg_data_i = {6'b0, mode, proto, port};
        tick();
        bus.cfg_wr_i = 1'b0;
    endtask

    // sop+protocol, then ports, then hdr_done; result visible on return.
    task automatic pkt(input logic pv, input logic [7:0] p, input logic sv,
                       input logic [15:0] s, input logic dv, input logic [15:0] d);
        bus.sop_i = 1'b1; bus.ip_prot_en_i = pv; bus.ip_prot_i = p;
        tick();
        bus.sop_i = 1'b0; bus.ip_prot_en_i = 1'b0;
        bus.port_src_en_i = sv; bus.port_src_i = s;
        bus.port_dst_en_i = dv; bus.port_dst_i = d;
        tick();
        bus.port_src_en_i = 1'b0; bus.port_dst_en_i = 1'b0;
        bus.hdr_done_i = 1'b1;
        sb_q.push_back(model(pv, p, sv, s, dv, d));
        tick();
        bus.hdr_done_i = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        for (int i = 0; i < RULES; i++) begin
            m_mode[i] = '0; m_proto[i] = '0; m_port[i] = '0;
        end
        rst_n = 1'b0;
        tick(); tick();
        checks++;
        if ({obs(), bus.cnt_rd_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h cnt=%h exp=0", obs(), bus.cnt_rd_o);
        end
        rst_n = 1'b1;
        tick(); tick();
        checks++;
        if ({obs(), bus.cnt_rd_o} !== '0) begin
            errors++;
            $display("FAIL reset_release got=%h cnt=%h exp=0", obs(), bus.cnt_rd_o);
        end
    endtask

    task automatic test_basic();
        cfg_write(0, 2'd1, 8'd6, 16'd22);
        pkt(1'b1, 8'd6, 1'b0, 16'd0, 1'b1, 16'd22);
        checks++;
        if (sb_q.size() == 0) begin
            errors++; $display("FAIL basic_sb got=empty exp=entry");
        end else begin
            exp_v = sb_q.pop_front();
            if (obs() !== {1'b1, exp_v}) begin
                errors++; $display("FAIL basic_result got=%h exp=%h", obs(), {1'b1, exp_v});
            end
        end
        checks++;
        if ({bus.rule_hit_o, bus.tcp_o, bus.first_hit_o} !== {8'h01, 1'b1, 3'd0}) begin
            errors++;
            $display("FAIL basic_const got=%h/%b/%0d exp=01/1/0", bus.rule_hit_o, bus.tcp_o, bus.first_hit_o);
        end
        tick();
        checks++;
        if ({bus.res_valid_o, bus.rule_hit_o} !== {1'b0, 8'h01}) begin
            errors++;
            $display("FAIL basic_hold got=%b/%h exp=0/01", bus.res_valid_o, bus.rule_hit_o);
        end
    endtask

    task automatic test_either();
        logic [7:0]  p;
        logic [15:0] s;
        logic [15:0] d;
        cfg_write(2, 2'd3, 8'd17, 16'd319);
        cfg_write(5, 2'd3, 8'd17, 16'd319);
        for (int k = 0; k < 4; k++) begin
            case (k)
                0:       begin p = 8'd17; s = 16'd319;  d = 16'd5000; end
                1:       begin p = 8'd17; s = 16'd1000; d = 16'd319;  end
                2:       begin p = 8'd6;  s = 16'd319;  d = 16'd319;  end
                default: begin p = 8'd1;  s = 16'd0;    d = 16'd0;    end
            endcase
            pkt(1'b1, p, 1'b1, s, 1'b1, d);
            checks++;
            if (sb_q.size() == 0) begin
                errors++; $display("FAIL either_sb_%0d got=empty exp=entry", k);
            end else begin
                exp_v = sb_q.pop_front();
                if (obs() !== {1'b1, exp_v}) begin
                    errors++; $display("FAIL either_result_%0d got=%h exp=%h", k, obs(), {1'b1, exp_v});
                end
            end
            if (k == 0) begin
                checks++;
                if ({bus.rule_hit_o, bus.first_hit_o, bus.udp_o} !== {8'h24, 3'd2, 1'b1}) begin
                    errors++;
                    $display("FAIL either_const got=%h/%0d/%b exp=24/2/1", bus.rule_hit_o, bus.first_hit_o, bus.udp_o);
                end
            end
        end
    endtask

    task automatic test_bypass();
        bus.sop_i = 1'b1; bus.ip_prot_en_i = 1'b1; bus.ip_prot_i = 8'd6;
        tick();
        bus.sop_i = 1'b0; bus.ip_prot_en_i = 1'b0;
        bus.hdr_done_i = 1'b1;
        sb_q.push_back(model(1'b1, 8'd6, 1'b0, 16'd0, 1'b0, 16'd0));
        tick();
        bus.hdr_done_i = 1'b0;
        checks++;
        if (sb_q.size() == 0) begin
            errors++; $display("FAIL bypass_noport_sb got=empty exp=entry");
        end else begin
            exp_v = sb_q.pop_front();
            if ((obs() !== {1'b1, exp_v}) || (bus.hit_any_o !== 1'b0)) begin
                errors++; $display("FAIL bypass_noport got=%h exp=%h", obs(), {1'b1, exp_v});
            end
        end
        tick();
        bus.hdr_done_i = 1'b1; bus.port_dst_en_i = 1'b1; bus.port_dst_i = 16'd22;
        sb_q.push_back(model(1'b1, 8'd6, 1'b0, 16'd0, 1'b1, 16'd22));
        tick();
        bus.hdr_done_i = 1'b0; bus.port_dst_en_i = 1'b0;
        checks++;
        if (sb_q.size() == 0) begin
            errors++; $display("FAIL bypass_hit_sb got=empty exp=entry");
        end else begin
            exp_v = sb_q.pop_front();
            if ((obs() !== {1'b1, exp_v}) || (bus.rule_hit_o[0] !== 1'b1)) begin
                errors++; $display("FAIL bypass_hit got=%h exp=%h", obs(), {1'b1, exp_v});
            end
        end
    endtask

    task automatic test_cfg_race();
        bus.sop_i = 1'b1; bus.ip_prot_en_i = 1'b1; bus.ip_prot_i = 8'd6;
        bus.port_dst_en_i = 1'b1; bus.port_dst_i = 16'd22;
        tick();
        bus.sop_i = 1'b0; bus.ip_prot_en_i = 1'b0; bus.port_dst_en_i = 1'b0;
        bus.hdr_done_i = 1'b1;
        sb_q.push_back(model(1'b1, 8'd6, 1'b0, 16'd0, 1'b1, 16'd22));
        cfg_write(0, 2'd0, 8'd6, 16'd22);
        bus.hdr_done_i = 1'b0;
        checks++;
        if (sb_q.size() == 0) begin
            errors++; $display("FAIL race_sb got=empty exp=entry");
        end else begin
            exp_v = sb_q.pop_front();
            if ((obs() !== {1'b1, exp_v}) || (bus.rule_hit_o[0] !== 1'b1)) begin
                errors++; $display("FAIL race_old_rule got=%h exp=%h", obs(), {1'b1, exp_v});
            end
        end
        pkt(1'b1, 8'd6, 1'b0, 16'd0, 1'b1, 16'd22);
        checks++;
        if (sb_q.size() == 0) begin
            errors++; $display("FAIL race_next_sb got=empty exp=entry");
        end else begin
            exp_v = sb_q.pop_front();
            if ((obs() !== {1'b1, exp_v}) || (bus.hit_any_o !== 1'b0)) begin
                errors++; $display("FAIL race_new_rule got=%h exp=%h", obs(), {1'b1, exp_v});
            end
        end
    endtask

    task automatic test_back_to_back();
        bus.sop_i = 1'b1; bus.ip_prot_en_i = 1'b1; bus.ip_prot_i = 8'd17;
        tick();
        bus.sop_i = 1'b0; bus.ip_prot_en_i = 1'b0;
        bus.hdr_done_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            case (k)
                0: begin
                    bus.port_dst_en_i = 1'b1; bus.port_dst_i = 16'd319;
                    sb_q.push_back(model(1'b1, 8'd17, 1'b0, 16'd0, 1'b1, 16'd319));
                end
                1: begin
                    bus.port_dst_en_i = 1'b1; bus.port_dst_i = 16'd7;
                    sb_q.push_back(model(1'b1, 8'd17, 1'b0, 16'd0, 1'b1, 16'd7));
                end
                default: begin
                    bus.port_dst_en_i = 1'b0;
                    bus.port_src_en_i = 1'b1; bus.port_src_i = 16'd319;
                    sb_q.push_back(model(1'b1, 8'd17, 1'b1, 16'd319, 1'b1, 16'd7));
                end
            endcase
            tick();
            checks++;
            if (sb_q.size() == 0) begin
                errors++; $display("FAIL b2b_sb_%0d got=empty exp=entry", k);
            end else begin
                exp_v = sb_q.pop_front();
                if (obs() !== {1'b1, exp_v}) begin
                    errors++; $display("FAIL b2b_result_%0d got=%h exp=%h", k, obs(), {1'b1, exp_v});
                end
            end
        end
        bus.hdr_done_i = 1'b0; bus.port_src_en_i = 1'b0;
        tick();
        checks++;
        if (bus.res_valid_o !== 1'b0) begin
            errors++; $display("FAIL b2b_drop got=%b exp=0", bus.res_valid_o);
        end
    endtask

    task automatic test_clken();
        bus.sop_i = 1'b1; bus.ip_prot_en_i = 1'b1; bus.ip_prot_i = 8'd17;
        tick();
        bus.sop_i = 1'b0; bus.ip_prot_en_i = 1'b0;
        bus.clken_i = 1'b0; bus.hdr_done_i = 1'b1;
        bus.port_dst_en_i = 1'b1; bus.port_dst_i = 16'd319;
        sb_q.push_back(model(1'b1, 8'd17, 1'b0, 16'd0, 1'b0, 16'd0));
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (bus.res_valid_o !== 1'b0) begin
                errors++; $display("FAIL clken_frozen_%0d got=%b exp=0", k, bus.res_valid_o);
            end
        end
        bus.port_dst_en_i = 1'b0; bus.clken_i = 1'b1;
        tick();
        bus.hdr_done_i = 1'b0;
        checks++;
        if (sb_q.size() == 0) begin
            errors++; $display("FAIL clken_sb got=empty exp=entry");
        end else begin
            exp_v = sb_q.pop_front();
            if (obs() !== {1'b1, exp_v}) begin
                errors++; $display("FAIL clken_result got=%h exp=%h", obs(), {1'b1, exp_v});
            end
        end
        bus.clken_i = 1'b0;
        tick(); tick();
        checks++;
        if (bus.res_valid_o !== 1'b1) begin
            errors++; $display("FAIL clken_hold got=%b exp=1", bus.res_valid_o);
        end
        bus.clken_i = 1'b1;
        tick();
        checks++;
        if (bus.res_valid_o !== 1'b0) begin
            errors++; $display("FAIL clken_release got=%b exp=0", bus.res_valid_o);
        end
    endtask

    task automatic test_counters();
        cfg_write(1, 2'd1, 8'd17, 16'd53);
        bus.cnt_clr_i = 1'b1;
        tick();
        bus.cnt_clr_i = 1'b0;
        bus.sop_i = 1'b1; bus.ip_prot_en_i = 1'b1; bus.ip_prot_i = 8'd17;
        bus.port_dst_en_i = 1'b1; bus.port_dst_i = 16'd53;
        tick();
        bus.sop_i = 1'b0; bus.ip_prot_en_i = 1'b0; bus.port_dst_en_i = 1'b0;
        bus.hdr_done_i = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        bus.hdr_done_i = 1'b0;
        bus.cfg_addr_i = 3'd1;
        tick(); tick();
`ifdef TCP_UDP_RULE_CNT_EN
        checks++;
        if (bus.cnt_rd_o !== 8'd5) begin
            errors++; $display("FAIL cnt_five got=%0d exp=5", bus.cnt_rd_o);
        end
        bus.cfg_addr_i = 3'd2;
        tick(); tick();
        checks++;
        if (bus.cnt_rd_o !== 8'd0) begin
            errors++; $display("FAIL cnt_other got=%0d exp=0", bus.cnt_rd_o);
        end
        bus.hdr_done_i = 1'b1;
        for (int k = 0; k < 295; k++) tick();
        bus.hdr_done_i = 1'b0;
        bus.cfg_addr_i = 3'd1;
        tick(); tick();
        checks++;
        if (bus.cnt_rd_o !== 8'd255) begin
            errors++; $display("FAIL cnt_saturate got=%0d exp=255", bus.cnt_rd_o);
        end
        bus.hdr_done_i = 1'b1; bus.cnt_clr_i = 1'b1;
        tick();
        bus.hdr_done_i = 1'b0; bus.cnt_clr_i = 1'b0;
        tick();
        checks++;
        if (bus.cnt_rd_o !== 8'd0) begin
            errors++; $display("FAIL cnt_clear_wins got=%0d exp=0", bus.cnt_rd_o);
        end
`else
        checks++;
        if (bus.cnt_rd_o !== 8'd0) begin
            errors++; $display("FAIL cnt_disabled got=%0d exp=0", bus.cnt_rd_o);
        end
`endif
        bus.cfg_addr_i = 3'd0;
    endtask

    task automatic test_reset_mid();
        cfg_write(0, 2'd1, 8'd6, 16'd22);
        pkt(1'b1, 8'd6, 1'b0, 16'd0, 1'b1, 16'd22);
        checks++;
        if (sb_q.size() == 0) begin
            errors++; $display("FAIL rstmid_pre_sb got=empty exp=entry");
        end else begin
            exp_v = sb_q.pop_front();
            if (obs() !== {1'b1, exp_v}) begin
                errors++; $display("FAIL rstmid_pre got=%h exp=%h", obs(), {1'b1, exp_v});
            end
        end
        bus.sop_i = 1'b1; bus.ip_prot_en_i = 1'b1; bus.ip_prot_i = 8'd6;
        bus.port_dst_en_i = 1'b1; bus.port_dst_i = 16'd22;
        tick();
        bus.sop_i = 1'b0; bus.ip_prot_en_i = 1'b0; bus.port_dst_en_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({obs(), bus.cnt_rd_o} !== '0) begin
            errors++; $display("FAIL rstmid_outputs got=%h cnt=%h exp=0", obs(), bus.cnt_rd_o);
        end
        for (int i = 0; i < RULES; i++) begin
            m_mode[i] = '0; m_proto[i] = '0; m_port[i] = '0;
        end
        tick();
        rst_n = 1'b1;
        tick(); tick();
        checks++;
        if (bus.res_valid_o !== 1'b0) begin
            errors++; $display("FAIL rstmid_no_result got=%b exp=0", bus.res_valid_o);
        end
        bus.hdr_done_i = 1'b1;
        sb_q.push_back(model(1'b0, 8'd0, 1'b0, 16'd0, 1'b0, 16'd0));
        tick();
        bus.hdr_done_i = 1'b0;
        checks++;
        if (sb_q.size() == 0) begin
            errors++; $display("FAIL rstmid_empty_sb got=empty exp=entry");
        end else begin
            exp_v = sb_q.pop_front();
            if (obs() !== {1'b1, exp_v}) begin
                errors++; $display("FAIL rstmid_discard got=%h exp=%h", obs(), {1'b1, exp_v});
            end
        end
        pkt(1'b1, 8'd6, 1'b0, 16'd0, 1'b1, 16'd22);
        checks++;
        if (sb_q.size() == 0) begin
            errors++; $display("FAIL rstmid_table_sb got=empty exp=entry");
        end else begin
            exp_v = sb_q.pop_front();
            if ((obs() !== {1'b1, exp_v}) || (bus.hit_any_o !== 1'b0)) begin
                errors++; $display("FAIL rstmid_table_off got=%h exp=%h", obs(), {1'b1, exp_v});
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_either();
        test_bypass();
        test_cfg_race();
        test_back_to_back();
        test_clken();
        test_counters();
        test_reset_mid();
        checks++;
        if (sb_q.size() != 0) begin
            errors++; $display("FAIL sb_leftover got=%0d exp=0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tcp_udp_rule_classer.md
# tcp_udp_rule_classer

Parametrised L4 classifier with a run-time programmable rule table, replacing fixed-port TCP/UDP matching. It captures IP protocol and source/destination ports as the header parser emits them, evaluates all rules when the header is complete, and registers a per-rule hit vector plus TCP/UDP/ICMP flags. Optional per-rule saturating hit counters are readable over the configuration port. It sits after the L3/L4 header parser, beside the L2 classer, and feeds the traffic-class decision logic.

## Interface
- RULES, 8: number of rule slots, 2..32
- CNT_W, 32: hit counter width, 8..32
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous reset, active-low
- clken_i  in  1  datapath clock enable
- sop_i  in  1  start of packet; clears captured fields
- ip_prot_i / ip_prot_en_i  in  8 / 1  IP protocol and its strobe
- port_src_i / port_src_en_i  in  16 / 1  L4 source port and its strobe
- port_dst_i / port_dst_en_i  in  16 / 1  L4 destination port and its strobe
- hdr_done_i  in  1  header complete; triggers evaluation
- cfg_wr_i  in  1  rule write strobe
- cfg_addr_i  in  $clog2(RULES)  rule or counter index
- cfg_data_i  in  32  rule word: [15:0] port, [23:16] proto, [25:24] mode (0 off, 1 dst, 2 src, 3 either)
- cnt_clr_i  in  1  clear all counters
- cnt_rd_o  out  CNT_W  counter selected by cfg_addr_i
- res_valid_o  out  1  result strobe
- rule_hit_o  out  RULES  per-rule hit vector
- hit_any_o  out  1  OR of rule_hit_o
- first_hit_o  out  $clog2(RULES)  lowest hit index; 0 when none
- tcp_o / udp_o / icmp_o  out  1  protocol flags (6 / 17 / 1)

## Operation
- Capture: each field is latched with a sticky valid flag on its strobe when clken_i=1. sop_i with clken_i clears all flags; a strobe in the same cycle as sop_i captures the new value, so the flag ends set.
- Bypass: a strobe coincident with hdr_done_i is used in that evaluation.
- Rule hit: mode≠0, protocol valid and equal to the rule proto, and port match. dst and src modes need that port valid and equal. Either mode needs a valid, equal source or destination port. An unseen field never matches.
- hdr_done_i without a prior sop_i evaluates the current flags.
- Rule table is written on cfg_wr_i regardless of clken_i. A write and hdr_done_i in the same cycle evaluate against the old rule.
- Counters (macro-gated): at the edge where res_valid_o rises, each hit rule's counter increments and saturates at all-ones. cnt_clr_i ignores clken_i and wins over a coincident increment.

## Timing
- Reset: all outputs 0, rule table 0 (all off), counters 0, capture flags 0.
- hdr_done_i at edge T with clken_i=1 -> res_valid_o high for exactly the next clken_i cycle. rule_hit_o, hit_any_o, first_hit_o and the protocol flags are valid alongside it and hold until the next result.
- clken_i=0 freezes capture, results and counter increments. res_valid_o holds its value.
- cnt_rd_o is registered: data for cfg_addr_i appears 1 clk later and is updated every clk.
- Back-to-back hdr_done_i on consecutive clken cycles gives one result per cycle.
- Reset mid-packet discards captured fields. No result is produced until the next hdr_done_i.

## Configuration
- TCP_UDP_RULE_CNT_EN: defined -> RULES x CNT_W saturating counters, cnt_clr_i and cnt_rd_o are active. Undefined -> no counter storage, cnt_rd_o tied 0, cnt_clr_i ignored.

## Structure
- Package tcp_udp_rule_pkg holds:
  - rule_t struct (port, proto, mode)
  - mode enum
  - TCP_PROTO, UDP_PROTO, ICMP_PROTO constants
  - cfg_data_i field offsets
- Sub-module tcp_udp_rule_match is a combinational single-rule comparator, instantiated RULES times via generate. The top level holds capture, table, priority encoder, output registers and counters.

## Test plan
- Rule 0 = {proto 6, port 22, dst}; sop, proto 6, dst 22, hdr_done -> next cycle res_valid_o=1, rule_hit_o[0]=1, tcp_o=1, first_hit_o=0.
- Rules 2 and 5 = {17, 319, either}; UDP src 319, dst 5000 -> rule_hit_o bits 2 and 5 set, first_hit_o=2, udp_o=1.
- Protocol but no port strobe before hdr_done_i -> hit_any_o=0. Then a port strobe coincident with the next hdr_done_i -> hit (bypass).
- cfg_wr_i disabling rule 0 in the same cycle as hdr_done_i -> hit still reported. The next packet reports no hit.
- With TCP_UDP_RULE_CNT_EN and CNT_W=8: 300 hits on rule 1 -> cnt_rd_o=255. cnt_clr_i coincident with a hit -> 0.
- clken_i=0 for 3 cycles around hdr_done_i: res_valid_o is delayed until clken_i returns. rst_n_i low mid-packet -> all outputs 0.
